// File: rtl/key_expander_pkg.sv
// Shared AES key-schedule constants: word sizes, key_len encodings,
// per-mode Nk/Nr, the Rcon sequence and the forward S-box.
package key_expander_pkg;

  localparam int BYTE_S = 8;
  localparam int WORD_S = 32;
  localparam int BLK_S  = 128;

  localparam int KEY_S_128 = 128;
  localparam int KEY_S_192 = 192;
  localparam int KEY_S_256 = 256;

  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Rcon[1] = 01; indices outside 1..10 never reach a RotWord step.
  function automatic logic [BYTE_S-1:0] rcon(input logic [3:0] idx);
    logic [BYTE_S-1:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the table.
  function automatic logic [BYTE_S-1:0] sbox(input logic [BYTE_S-1:0] b);
    return SBOX_TABLE[8*(255-int'(b)) +: 8];
  endfunction

endpackage

// File: rtl/key_expander_sbox_word.sv
// Combinational 4-byte S-box lookup; also used by the cipher SubBytes path.
module aes_sbox_word
  import key_expander_pkg::*;
(
  input  logic [WORD_S-1:0] word_i,
  output logic [WORD_S-1:0] word_o
);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_byte
    assign word_o[gi*BYTE_S +: BYTE_S] = sbox(word_i[gi*BYTE_S +: BYTE_S]);
  end

endmodule

// File: rtl/key_expander.sv
// Word-serial AES-128/192/256 key expander: one schedule word per cycle,
// packed four at a time into round keys on a valid/ready output port.
module key_expander
  import key_expander_pkg::*;
#(
  parameter int MAX_KEY_S   = 256,
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           key_len,
  input  logic [MAX_KEY_S-1:0] key,
  output logic                 busy,
  output logic [BLK_S-1:0]     rk_data,
  output logic [3:0]           rk_round,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic                 rk_last,
  output logic                 done
);

  // A mode is only reachable if the key port is wide enough to carry it.
  localparam bit SUP_192 = SUPPORT_192 && (MAX_KEY_S >= KEY_S_192);
  localparam bit SUP_256 = SUPPORT_256 && (MAX_KEY_S >= KEY_S_256);

  logic [1:0]           state_q, state_d;
  logic [KEY_S_256-1:0] key_q, key_d;
  logic [3:0]           nk_q, nk_d, nr_q, nr_d;
  logic [5:0]           widx_q, widx_d;
  logic [2:0]           sub_q, sub_d;
  logic [3:0]           rcon_idx_q, rcon_idx_d;
  logic [WORD_S-1:0]    win_q [8];
  logic [WORD_S-1:0]    win_d [8];
  logic [WORD_S-1:0]    buf_q [4];
  logic [WORD_S-1:0]    buf_d [4];
  logic [1:0]           bcnt_q, bcnt_d;
  logic [3:0]           round_q, round_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [BLK_S-1:0]     rk_data_q, rk_data_d;
  logic [3:0]           rk_round_q, rk_round_d;
  logic                 rk_valid_q, rk_valid_d, rk_last_q, rk_last_d;

  logic [3:0]        nk_sel, nr_sel;
  logic [WORD_S-1:0] key_words [8];
  logic [WORD_S-1:0] key_word, sbox_in, sbox_out, temp, new_word;
  logic [2:0]        nk_idx;
  logic [5:0]        last_idx;
  logic              stall, drain;

  always_comb begin
    nk_sel = NK_128;
    nr_sel = NR_128;
    if (SUP_192 && key_len == KEY_LEN_192) begin
      nk_sel = NK_192;
      nr_sel = NR_192;
    end else if (SUP_256 && key_len == KEY_LEN_256) begin
      nk_sel = NK_256;
      nr_sel = NR_256;
    end
  end

  // Key is held MSB-aligned in a 256-bit register; word 0 is the top word.
  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_key_words
    assign key_words[gi] = key_q[KEY_S_256-1-WORD_S*gi -: WORD_S];
  end

  assign key_word = key_words[widx_q[2:0]];
  assign nk_idx   = 3'(nk_q - 4'd1);
  assign last_idx = {nr_q, 2'b11};

  // Window slot 0 is w[i-1], slot Nk-1 is w[i-Nk].
  assign sbox_in = (sub_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

  aes_sbox_word u_sbox (
    .word_i (sbox_in),
    .word_o (sbox_out)
  );

  always_comb begin
    temp = win_q[0];
    if (sub_q == 3'd0)
      temp = sbox_out ^ {rcon(rcon_idx_q), 24'h000000};
    else if (nk_q == NK_256 && sub_q == 3'd4)
      temp = sbox_out;
    new_word = (widx_q < 6'(nk_q)) ? key_word : (win_q[nk_idx] ^ temp);
  end

  assign drain = rk_valid_q && rk_ready;
  assign stall = (bcnt_q == 2'd3) && rk_valid_q && !rk_ready;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    widx_d     = widx_q;
    sub_d      = sub_q;
    rcon_idx_d = rcon_idx_q;
    win_d      = win_q;
    buf_d      = buf_q;
    bcnt_d     = bcnt_q;
    round_d    = round_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    rk_last_d  = rk_last_q;

    if (drain) begin
      rk_valid_d = 1'b0;
      rk_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_RUN;
          key_d      = KEY_S_256'(key) << (KEY_S_256 - MAX_KEY_S);
          nk_d       = nk_sel;
          nr_d       = nr_sel;
          widx_d     = 6'd0;
          sub_d      = 3'd0;
          rcon_idx_d = 4'd0;
          bcnt_d     = 2'd0;
          round_d    = 4'd0;
          busy_d     = 1'b1;
          win_d      = '{default: '0};
        end
      end
      ST_RUN: begin
        if (!stall) begin
          win_d[0] = new_word;
          for (int k = 1; k < 8; k++) win_d[k] = win_q[k-1];
          // Fourth word goes straight to the output register with the buffer.
          if (bcnt_q == 2'd3) begin
            rk_data_d  = {buf_q[0], buf_q[1], buf_q[2], new_word};
            rk_round_d = round_q;
            rk_last_d  = (round_q == nr_q);
            rk_valid_d = 1'b1;
            round_d    = round_q + 4'd1;
            bcnt_d     = 2'd0;
          end else begin
            buf_d[bcnt_q] = new_word;
            bcnt_d        = bcnt_q + 2'd1;
          end
          widx_d = widx_q + 6'd1;
          if (sub_q == nk_idx) begin
            sub_d      = 3'd0;
            rcon_idx_d = rcon_idx_q + 4'd1;
          end else begin
            sub_d = sub_q + 3'd1;
          end
          if (widx_q == last_idx) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      nk_q       <= '0;
      nr_q       <= '0;
      widx_q     <= '0;
      sub_q      <= '0;
      rcon_idx_q <= '0;
      win_q      <= '{default: '0};
      buf_q      <= '{default: '0};
      bcnt_q     <= '0;
      round_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      widx_q     <= widx_d;
      sub_q      <= sub_d;
      rcon_idx_q <= rcon_idx_d;
      win_q      <= win_d;
      buf_q      <= buf_d;
      bcnt_q     <= bcnt_d;
      round_q    <= round_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rk_data  = rk_data_q;
  assign rk_round = rk_round_q;
  assign rk_valid = rk_valid_q;
  assign rk_last  = rk_last_q;

endmodule

// File: tb/tb_key_expander.sv
// Directed bench for key_expander: FIPS-197 vectors plus an independent
// GF(2^8)-derived reference schedule, backpressure, busy/key_len and reset cases.
module tb_key_expander;

  logic         clk = 1'b0;
  logic         reset, en, rk_ready, busy, rk_valid, rk_last, done;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]  mw     [60];
  logic [127:0] exp_rk [15];
  logic [127:0] cap    [15];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  key_expander #(.MAX_KEY_S(256), .SUPPORT_192(1'b1), .SUPPORT_256(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .key_len  (key_len),
    .key      (key),
    .busy     (busy),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_last  (rk_last),
    .done     (done)
  );

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
    for (int r = 0; r <= nk + 6; r++) exp_rk[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endtask

  task automatic run_exp(input string tag, input logic [255:0] k, input logic [1:0] kl,
                         input int nk, input bit stall, input bit glitch);
    int nr, got, cyc, hold_left;
    bit hold_prev;
    logic [127:0] held;
    nr = nk + 6; got = 0; cyc = 0; hold_left = 0; hold_prev = 1'b0; held = '0;
    model_expand(k, nk);
    @(negedge clk);
    key = k; key_len = kl; en = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check_vec({tag, " busy"}, 128'(busy), 128'(1));
    while (got <= nr && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (glitch && cyc == 5) begin
        key = ~k; key_len = 2'b10; en = 1'b1;
      end else if (glitch && cyc == 6) begin
        en = 1'b0;
      end
      if (hold_prev) check_vec({tag, " hold"}, rk_data, held);
      hold_prev = 1'b0;
      if (rk_valid) begin
        if (!stall) rk_ready = 1'b1;
        else if (hold_left > 0) begin rk_ready = 1'b0; hold_left--; end
        else if ($urandom_range(0, 15) == 0) begin rk_ready = 1'b0; hold_left = 19; end
        else rk_ready = 1'($urandom_range(0, 1));
        if (rk_ready) begin
          check_vec($sformatf("%s r%0d data", tag, got), rk_data, exp_rk[got]);
          check_vec($sformatf("%s r%0d round", tag, got), 128'(rk_round), 128'(got));
          check_vec($sformatf("%s r%0d last", tag, got), 128'(rk_last), 128'(got == nr));
          if (!stall) check_vec($sformatf("%s r%0d latency", tag, got), 128'(cyc), 128'(4*got+4));
          $display("%s round %0d rk %h at cycle %0d", tag, got, rk_data, cyc);
          cap[got] = rk_data;
          got++;
        end else begin
          hold_prev = 1'b1;
          held      = rk_data;
        end
      end else begin
        rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    check_vec({tag, " count"}, 128'(got), 128'(nr+1));
    @(negedge clk);
    check_vec({tag, " done/busy/valid"}, 128'({done, busy, rk_valid}), 128'(3'b100));
    @(negedge clk);
    check_vec({tag, " done width"}, 128'(done), 128'(0));
    key = k; key_len = kl; rk_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  saw;
    reset = 1'b1; en = 1'b0; rk_ready = 1'b0; key = '0; key_len = 2'b00;
    repeat (3) @(negedge clk);
    check_vec("reset ctl", 128'({rk_valid, busy, done, rk_last, rk_round}), 128'(0));
    check_vec("reset data", rk_data, 128'(0));
    reset = 1'b0;

    run_exp("aes128", K128, 2'b00, 4, 1'b0, 1'b0);
    check_vec("aes128 r0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check_vec("aes128 r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_vec("aes128 r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_exp("aes192", K192, 2'b01, 6, 1'b0, 1'b0);
    check_vec("aes192 r1", cap[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check_vec("aes192 r12", cap[12], 128'he98ba06f448c773c8ecc720401002202);

    run_exp("aes256", K256, 2'b10, 8, 1'b0, 1'b0);
    check_vec("aes256 r2", cap[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check_vec("aes256 r14", cap[14], 128'hfe4890d1e6188d0b046df344706c631e);

    run_exp("bp128", K128, 2'b00, 4, 1'b1, 1'b0);
    check_vec("bp128 r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_vec("bp128 r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_exp("en_busy", K128, 2'b00, 4, 1'b0, 1'b1);
    check_vec("en_busy r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_exp("klen11", K128, 2'b11, 4, 1'b0, 1'b0);
    check_vec("klen11 r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_vec("klen11 r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Abort: round 3 is taken at cycle 16, so cycle 18 sits before round 4 appears.
    @(negedge clk);
    key = K128; key_len = 2'b00; en = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cyc = 0;
    while (cyc < 18) begin
      @(negedge clk);
      cyc++;
    end
    check_vec("abort pre r3", 128'(rk_round), 128'(3));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_vec("abort ctl", 128'({rk_valid, busy, done}), 128'(0));
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || rk_valid) saw = 1'b1;
    end
    check_vec("abort quiet", 128'(saw), 128'(0));

    run_exp("post_reset", K128, 2'b00, 4, 1'b0, 1'b0);
    check_vec("post_reset r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
